// File: rtl/pkt_snd.sv
// rtl/pkt_snd.sv - 3-wire serial packet transmitter (sclk/sdo/load) with req/ack completion handshake.
module pkt_snd #(
  parameter int W       = 16,
  parameter int CLK_DIV = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         preq,
  input  logic [W-1:0] pkt,
  output logic         sclk,
  output logic         load,
  output logic         sdo,
  output logic         psnt
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(W);
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_MAX = BW'(W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t         state;
  logic [W-1:0]   shreg;
  logic [DW-1:0]  div;
  logic [BW-1:0]  bitcnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      shreg  <= '0;
      div    <= '0;
      bitcnt <= '0;
      sclk   <= 1'b0;
      load   <= 1'b1;
      sdo    <= 1'b0;
      psnt   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (preq) begin
            shreg  <= pkt;
            sdo    <= pkt[W-1];
            load   <= 1'b0;
            sclk   <= 1'b0;
            div    <= '0;
            bitcnt <= '0;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          // Every CLK_DIV cycles sclk toggles; a falling edge also advances the data bit.
          if (div == DIV_MAX) begin
            div <= '0;
            if (!sclk) begin
              sclk <= 1'b1;
            end else if (bitcnt == BIT_MAX) begin
              sclk  <= 1'b0;
              sdo   <= 1'b0;
              load  <= 1'b1;
              psnt  <= 1'b1;
              state <= DONE;
            end else begin
              sclk   <= 1'b0;
              sdo    <= shreg[W-2];
              shreg  <= {shreg[W-2:0], 1'b0};
              bitcnt <= bitcnt + 1'b1;
            end
          end else begin
            div <= div + 1'b1;
          end
        end
        DONE: begin
          if (!preq) begin
            psnt  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pkt_snd.sv
// tb/tb_pkt_snd.sv - randomized self-checking bench for pkt_snd (CLK_DIV=1 and CLK_DIV=4 instances).
module tb_pkt_snd;

  logic        clk = 1'b0;
  logic        rst;
  logic        preq0, preq1;
  logic [15:0] pkt;
  logic        sclk0, load0, sdo0, psnt0;
  logic        sclk1, load1, sdo1, psnt1;
  int          checks = 0;
  int          failures = 0;
  int          sel = 0;

  always #5 clk = ~clk;

  pkt_snd #(.W(16), .CLK_DIV(1)) dut0 (
    .clk(clk), .rst(rst), .preq(preq0), .pkt(pkt),
    .sclk(sclk0), .load(load0), .sdo(sdo0), .psnt(psnt0)
  );

  pkt_snd #(.W(16), .CLK_DIV(4)) dut1 (
    .clk(clk), .rst(rst), .preq(preq1), .pkt(pkt),
    .sclk(sclk1), .load(load1), .sdo(sdo1), .psnt(psnt1)
  );

  wire o_sclk = sel ? sclk1 : sclk0;
  wire o_load = sel ? load1 : load0;
  wire o_sdo  = sel ? sdo1  : sdo0;
  wire o_psnt = sel ? psnt1 : psnt0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_preq(input logic v);
    if (sel != 0) preq1 = v; else preq0 = v;
  endtask

  // One transfer: the model expects the packet bits MSB first, one per sclk
  // rising edge, rising edges at (1+2i)*div and load back high at 2*16*div.
  task automatic run_pkt(input int s, input logic [15:0] p, input int mid_bit, input int hold);
    int div, k, rises, first_rise, viol, load_hi_k;
    logic [15:0] bits;
    logic ps, pl, pd;
    sel = s;
    div = (s != 0) ? 4 : 1;
    @(negedge clk);
    pkt = p;
    set_preq(1'b1);
    @(posedge clk);
    @(negedge clk);
    k = 0; rises = 0; first_rise = -1; viol = 0; load_hi_k = -1; bits = '0;
    check("load_low_after_t0", o_load, 1'b0);
    ps = o_sclk; pl = o_load; pd = o_sdo;
    while (load_hi_k < 0 && k < 40 * div) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      if (o_sclk && o_sdo !== pd) viol++;
      if (!o_load && pl && (o_sclk || ps)) viol++;
      if (o_sclk && !ps) begin
        bits = {bits[14:0], o_sdo};
        if (first_rise < 0) first_rise = k;
        rises++;
        if (rises == mid_bit) begin
          pkt = 16'hFFFF;
          set_preq(1'b0);
        end
      end
      if (o_load) load_hi_k = k;
      ps = o_sclk; pl = o_load; pd = o_sdo;
    end
    check("sampled_bits", bits, p);
    check("rise_count", rises, 16);
    check("first_rise_cycle", first_rise, div);
    check("load_rise_cycle", load_hi_k, 32 * div);
    check("psnt_with_load", o_psnt, 1'b1);
    check("sclk_idle_done", o_sclk, 1'b0);
    check("protocol_violations", viol, 0);
    if (mid_bit > 0) begin
      @(negedge clk);
      check("psnt_pulse_end", o_psnt, 1'b0);
    end else begin
      int hi = 0;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (o_psnt) hi++;
      end
      check("psnt_held", hi, hold);
      set_preq(1'b0);
      @(negedge clk);
      check("psnt_drop", o_psnt, 1'b0);
      check("load_idle", o_load, 1'b1);
    end
  endtask

  initial begin
    int rises;
    logic pprev;
    rst = 1'b1; preq0 = 1'b0; preq1 = 1'b0; pkt = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_sclk", sclk0, 1'b0);
    check("rst_load", load0, 1'b1);
    check("rst_sdo", sdo0, 1'b0);
    check("rst_psnt", psnt0, 1'b0);
    check("rst_load_div4", load1, 1'b1);
    rst = 1'b0;

    run_pkt(0, 16'hABCD, 0, 70);
    run_pkt(0, 16'h00EF, 0, 3);
    run_pkt(0, 16'hABCD, 5, 0);
    run_pkt(1, 16'h8001, 0, 2);

    // Asynchronous reset mid-transfer
    sel = 0;
    @(negedge clk);
    pkt = 16'hFFFF; preq0 = 1'b1;
    repeat (9) @(negedge clk);
    #2 rst = 1'b1; preq0 = 1'b0;
    #1;
    check("midrst_sclk", sclk0, 1'b0);
    check("midrst_load", load0, 1'b1);
    check("midrst_sdo", sdo0, 1'b0);
    check("midrst_psnt", psnt0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    rises = 0; pprev = sclk0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (sclk0 && !pprev) rises++;
      pprev = sclk0;
    end
    check("no_sclk_after_rst", rises, 0);
    check("load_high_after_rst", load0, 1'b1);

    for (int n = 0; n < 8; n++) begin
      run_pkt((n % 4 == 3) ? 1 : 0, 16'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15)) : 0,
              int'($urandom_range(0, 4)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pkt_snd.md
Name: pkt_snd

Overview:
- Serial packet transmitter for a MAX7219-style LED/display driver on a 3-wire SPI link (SCLK, DIN, LOAD).
- Latches a W-bit word on a level request and shifts it out MSB first with LOAD held low.
- Raises LOAD to latch the word in the slave.
- Reports completion on psnt using a four-phase req/ack handshake with the upstream controller.

Parameters:
- W, 16, packet width in bits (minimum 2).
- CLK_DIV, 1, clk cycles per SCLK half-period (minimum 1); SCLK frequency = f_clk / (2*CLK_DIV).

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  reset, asynchronous, active-high.
- preq  input  1  packet request, level; held high until psnt seen.
- pkt  input  W  packet data; sampled only in the acceptance cycle.
- sclk  output  1  serial clock to slave; idle low.
- load  output  1  slave chip-select/latch; idle high, low during shifting.
- sdo  output  1  serial data, MSB first; changes only while sclk is low.
- psnt  output  1  packet-sent acknowledge.

Behaviour:
- All outputs are registered, with no combinational paths from inputs.
- Reset (async assert, any state, including mid-transfer): abort any transfer; state IDLE; sclk=0, load=1, sdo=0, psnt=0; shift register, bit and divider counters cleared.
- States: IDLE, SHIFT, DONE.
- IDLE
  - On a clk edge with preq=1: latch pkt into the shift register; load<=0, sdo<=pkt[W-1], sclk<=0; divider counter cleared; go to SHIFT. This edge is t0.
  - On a clk edge with preq=0: stay in IDLE.
- SHIFT
  - Each phase lasts CLK_DIV cycles.
  - Setup phase: sclk=0, sdo stable.
  - Then, for each bit i = 0..W-1, a high phase (sclk=1, slave samples on the rising edge), followed by the falling-edge action.
  - Falling-edge action for i<W-1: sclk<=0 and sdo<=next lower bit.
  - Falling-edge action for i=W-1: sclk<=0, sdo<=0, load<=1, psnt<=1; go to DONE.
  - Timing: the rising edge of bit i occurs at t0+(1+2i)*CLK_DIV. With defaults, load rises at t0+32*CLK_DIV = t0+32 and there are exactly 16 sclk pulses.
- DONE
  - psnt=1, load=1, sclk=0.
  - Stay in DONE while preq=1.
  - On an edge with preq=0: psnt<=0; go to IDLE.
- A new transfer requires at least one IDLE cycle. This guarantees at least 2 cycles of load high between packets.
- preq dropping during SHIFT is ignored: the transfer completes, psnt is high for at least one cycle, then the block returns to IDLE.
- pkt changes after t0 have no effect on the current transfer.
- preq still high in IDLE after a completed handshake is impossible by construction, since DONE waits for preq=0.
- Bit order: pkt[W-1] first, pkt[0] last.

Test Plan:
- Reset check: assert rst for 2 cycles -> sclk=0, load=1, sdo=0, psnt=0. Assert rst mid-SHIFT -> same values immediately (asynchronous), no further sclk edges.
- Single packet, defaults: pkt=16'hABCD, preq=1 -> load falls at t0+1 cycle; 16 sclk rising edges; sdo sampled at the rising edges = 1010_1011_1100_1101; load rises and psnt=1 at t0+32; psnt stays high while preq=1.
- Handshake and second packet: hold preq 70 cycles, then drop it -> psnt falls next edge. Then set pkt=16'h00EF, preq=1 -> sampled bits 0000_0000_1110_1111, load rises 32 cycles after acceptance.
- Mid-transfer stimulus: change pkt to 16'hFFFF and drop preq at bit 5 -> remaining bits still follow 16'hABCD; psnt pulses one cycle; state returns to IDLE.
- Divider: CLK_DIV=4, pkt=16'h8001 -> sclk period 8 cycles, load low for 128 cycles, sdo=1 only at the first and last rising edges.
- Protocol checker over random packets: sdo never changes while sclk=1; load never falls while sclk=1; exactly W rising edges per load-low window.
